// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point FFT frame controller.
//   N_POINT       : samples per frame
//   IDX_W         : width of a bin/sample index
//   SIZE_DATA_DEF : default width of one IEEE-754 real or imaginary word
//   cplx_t        : one complex sample {re, im}
//   state_t       : frame controller FSM states
package fft8_pkg;

    localparam int unsigned N_POINT       = 8;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned SIZE_DATA_DEF = 32;

    // "real" is a reserved word, so the fields are re/im.
    typedef struct packed {
        logic [SIZE_DATA_DEF-1:0] re;
        logic [SIZE_DATA_DEF-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/fft8_frame_buf.sv
// 8-entry complex register file.
//   i_clk, i_rst            : clock, synchronous active-high reset (clears all entries)
//   i_wr_en/i_wr_idx/i_wr_* : write one entry
//   i_load_en/i_load_*      : overwrite all entries at once (wins over i_wr_en)
//   o_real/o_imag           : flat read-out, entry k at [k*SIZE_DATA +: SIZE_DATA]
module fft8_frame_buf
    import fft8_pkg::*;
#(
    parameter int unsigned SIZE_DATA = SIZE_DATA_DEF
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_wr_en,
    input  logic [IDX_W-1:0]               i_wr_idx,
    input  logic [SIZE_DATA-1:0]           i_wr_real,
    input  logic [SIZE_DATA-1:0]           i_wr_imag,
    input  logic                           i_load_en,
    input  logic [N_POINT*SIZE_DATA-1:0]   i_load_real,
    input  logic [N_POINT*SIZE_DATA-1:0]   i_load_imag,
    output logic [N_POINT*SIZE_DATA-1:0]   o_real,
    output logic [N_POINT*SIZE_DATA-1:0]   o_imag
);

    logic [N_POINT*SIZE_DATA-1:0] real_q, real_d;
    logic [N_POINT*SIZE_DATA-1:0] imag_q, imag_d;

    always_comb begin
        real_d = real_q;
        imag_d = imag_q;
        if (i_load_en) begin
            real_d = i_load_real;
            imag_d = i_load_imag;
        end else if (i_wr_en) begin
            real_d[i_wr_idx*SIZE_DATA +: SIZE_DATA] = i_wr_real;
            imag_d[i_wr_idx*SIZE_DATA +: SIZE_DATA] = i_wr_imag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            real_q <= '0;
            imag_q <= '0;
        end else begin
            real_q <= real_d;
            imag_q <= imag_d;
        end
    end

    assign o_real = real_q;
    assign o_imag = imag_q;

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame controller for the FFT_8Points core.
// Collects 8 complex samples on the s_* valid/ready stream, pulses o_fft_start, waits for a
// rising edge of i_fft_done (bounded by TIMEOUT_CYC), captures the 8 bins and replays them
// in bin order on the m_* valid/ready stream.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   s_valid/s_ready/s_*       : input sample stream
//   m_valid/m_ready/m_*       : output bin stream, m_idx = bin index, m_last with bin 7
//   o_fft_start, o_fft_x_*    : launch pulse and frame to the core
//   i_fft_X_*, i_fft_done     : bins and done level from the core
//   o_busy                    : a frame is in progress
//   o_timeout                 : one-cycle pulse when a frame is abandoned
module fft8_frame_ctrl
    import fft8_pkg::*;
#(
    parameter int unsigned SIZE_DATA   = SIZE_DATA_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [SIZE_DATA-1:0]           s_real,
    input  logic [SIZE_DATA-1:0]           s_imag,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [SIZE_DATA-1:0]           m_real,
    output logic [SIZE_DATA-1:0]           m_imag,
    output logic [2:0]                     m_idx,
    output logic                           m_last,
    output logic                           o_fft_start,
    output logic [N_POINT*SIZE_DATA-1:0]   o_fft_x_real,
    output logic [N_POINT*SIZE_DATA-1:0]   o_fft_x_imag,
    input  logic [N_POINT*SIZE_DATA-1:0]   i_fft_X_real,
    input  logic [N_POINT*SIZE_DATA-1:0]   i_fft_X_imag,
    input  logic                           i_fft_done,
    output logic                           o_busy,
    output logic                           o_timeout
);

    localparam int unsigned TIMER_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 done_dly_q, done_dly_d;

    logic                 in_wr;
    logic                 out_load;
    logic                 done_edge;
    logic [N_POINT*SIZE_DATA-1:0] out_real;
    logic [N_POINT*SIZE_DATA-1:0] out_imag;

    // Only a fresh 0->1 transition counts; a level left high by a previous frame is ignored.
    assign done_edge  = i_fft_done && !done_dly_q;
    assign done_dly_d = i_fft_done;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_real      = '0;
        m_imag      = '0;
        m_idx       = '0;
        m_last      = 1'b0;
        o_fft_start = 1'b0;
        o_timeout   = 1'b0;
        in_wr       = 1'b0;
        out_load    = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                s_ready = !i_rst;
                if (s_valid && s_ready) begin
                    in_wr = 1'b1;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                o_fft_start = !i_rst;
                timer_d     = '0;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                // Capture has priority over a timeout in the same cycle.
                if (done_edge) begin
                    out_load = 1'b1;
                    state_d  = S_DRAIN;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYC)) begin
                    o_timeout = !i_rst;
                    timer_d   = '0;
                    state_d   = S_LOAD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DRAIN: begin
                m_valid = 1'b1;
                m_real  = out_real[cnt_q*SIZE_DATA +: SIZE_DATA];
                m_imag  = out_imag[cnt_q*SIZE_DATA +: SIZE_DATA];
                m_idx   = cnt_q;
                m_last  = (cnt_q == 3'd7);
                if (m_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    assign o_busy = (state_q != S_LOAD) || (cnt_q != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            timer_q    <= '0;
            done_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            done_dly_q <= done_dly_d;
        end
    end

    fft8_frame_buf #(
        .SIZE_DATA (SIZE_DATA)
    ) in_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (in_wr),
        .i_wr_idx    (cnt_q),
        .i_wr_real   (s_real),
        .i_wr_imag   (s_imag),
        .i_load_en   (1'b0),
        .i_load_real ('0),
        .i_load_imag ('0),
        .o_real      (o_fft_x_real),
        .o_imag      (o_fft_x_imag)
    );

    fft8_frame_buf #(
        .SIZE_DATA (SIZE_DATA)
    ) out_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_wr_en     (1'b0),
        .i_wr_idx    ('0),
        .i_wr_real   ('0),
        .i_wr_imag   ('0),
        .i_load_en   (out_load),
        .i_load_real (i_fft_X_real),
        .i_load_imag (i_fft_X_imag),
        .o_real      (out_real),
        .o_imag      (out_imag)
    );

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Testbench for fft8_frame_ctrl: directed frames, scoreboard queue of expected bins,
// negedge monitor plus a stand-in core that raises done 20 cycles after start.
module tb_fft8_frame_ctrl;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic [2:0]  idx;
        logic        last;
    } bin_t;

    logic          i_clk;
    logic          i_rst;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_real;
    logic [31:0]   s_imag;
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_real;
    logic [31:0]   m_imag;
    logic [2:0]    m_idx;
    logic          m_last;
    logic          o_fft_start;
    logic [255:0]  o_fft_x_real;
    logic [255:0]  o_fft_x_imag;
    logic [255:0]  i_fft_X_real;
    logic [255:0]  i_fft_X_imag;
    logic          i_fft_done;
    logic          o_busy;
    logic          o_timeout;

    fft8_frame_ctrl #(
        .SIZE_DATA   (32),
        .TIMEOUT_CYC (255)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_real       (s_real),
        .s_imag       (s_imag),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_real       (m_real),
        .m_imag       (m_imag),
        .m_idx        (m_idx),
        .m_last       (m_last),
        .o_fft_start  (o_fft_start),
        .o_fft_x_real (o_fft_x_real),
        .o_fft_x_imag (o_fft_x_imag),
        .i_fft_X_real (i_fft_X_real),
        .i_fft_X_imag (i_fft_X_imag),
        .i_fft_done   (i_fft_done),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    bin_t        exp_q[$];
    logic [31:0] tx_re[8];
    logic [31:0] tx_im[8];
    int          ready_mode = 1;   // 0 low, 1 high, 2 random
    int          model_mode = 0;   // 0 normal, 1 never done, 2 done held high then re-edged
    int          cyc = 0;
    int          start_cyc = -1;
    int          drop_at = -1;
    int          rise_at = -1;
    int          rise_cyc = -1;
    int          exp_timeout_cyc = -1;
    int          n_starts = 0;
    int          n_timeouts = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bin_t mk_bin(input int k);
        bin_t b;
        b.re   = (k == 0) ? tx_re[0] : (tx_re[0] ^ tx_re[k]);
        b.im   = tx_im[k];
        b.idx  = 3'(k);
        b.last = (k == 7);
        return b;
    endfunction

    // Downstream ready driver.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stand-in core and monitor share one negedge process so their ordering is fixed.
    initial begin
        logic [31:0]  acc_re[8];
        logic [31:0]  acc_im[8];
        logic [255:0] exp_xr;
        logic [255:0] exp_xi;
        int           acc_cnt;
        bit           expect_start;
        bit           exp_sready_next;
        bit           prev_stall;
        bit           prev_m_valid;
        logic [67:0]  held;
        logic [67:0]  cur;
        bin_t         e;
        acc_cnt = 0;
        expect_start = 0;
        exp_sready_next = 0;
        prev_stall = 0;
        prev_m_valid = 0;
        held = '0;
        i_fft_done = 1'b0;
        i_fft_X_real = '0;
        i_fft_X_imag = '0;
        forever begin
            @(negedge i_clk);
            cyc++;
            // core model: X0 = x0, Xk = x0 ^ xk (real), Xk.im = xk.im
            if (o_fft_start && !i_rst) begin
                start_cyc = cyc;
                for (int k = 0; k < 8; k++) begin
                    i_fft_X_real[k*32 +: 32] = (k == 0) ? o_fft_x_real[31:0]
                                             : (o_fft_x_real[31:0] ^ o_fft_x_real[k*32 +: 32]);
                    i_fft_X_imag[k*32 +: 32] = o_fft_x_imag[k*32 +: 32];
                end
                if (model_mode == 1) begin
                    drop_at = cyc;
                    rise_at = -1;
                    exp_timeout_cyc = cyc + 256;
                end else if (model_mode == 2) begin
                    drop_at = cyc + 40;
                    rise_at = cyc + 42;
                    exp_timeout_cyc = -1;
                end else begin
                    drop_at = cyc;
                    rise_at = cyc + 20;
                    exp_timeout_cyc = -1;
                end
            end
            if (cyc == drop_at) i_fft_done = 1'b0;
            if (cyc == rise_at) begin
                i_fft_done = 1'b1;
                rise_cyc = cyc;
            end

            if (i_rst) begin
                acc_cnt = 0;
                expect_start = 0;
                exp_sready_next = 0;
                prev_stall = 0;
                prev_m_valid = 0;
            end else begin
                if (o_fft_start) n_starts++;
                if (o_timeout) n_timeouts++;
                if (expect_start || o_fft_start) begin
                    check(o_fft_start == expect_start, "start_pulse",
                          256'(o_fft_start), 256'(expect_start));
                    if (expect_start) begin
                        for (int k = 0; k < 8; k++) begin
                            exp_xr[k*32 +: 32] = acc_re[k];
                            exp_xi[k*32 +: 32] = acc_im[k];
                        end
                        check(o_fft_x_real == exp_xr, "fft_x_real", o_fft_x_real, exp_xr);
                        check(o_fft_x_imag == exp_xi, "fft_x_imag", o_fft_x_imag, exp_xi);
                    end
                    expect_start = 0;
                end
                if (s_valid && s_ready) begin
                    acc_re[acc_cnt] = s_real;
                    acc_im[acc_cnt] = s_imag;
                    acc_cnt++;
                    if (acc_cnt == 8) begin
                        acc_cnt = 0;
                        expect_start = 1;
                    end
                end
                if (exp_sready_next) begin
                    check(s_ready == 1'b1, "sready_after_last", 256'(s_ready), 256'(1));
                    exp_sready_next = 0;
                end
                if (m_valid && !prev_m_valid) begin
                    check(cyc == rise_cyc + 1, "first_valid_latency",
                          256'(cyc), 256'(rise_cyc + 1));
                end
                if (m_valid) begin
                    check(s_ready == 1'b0, "sready_low_in_drain", 256'(s_ready), 256'(0));
                end
                cur = {m_real, m_imag, m_idx, m_last};
                if (prev_stall) begin
                    check(m_valid && (cur == held), "hold_while_stalled",
                          {187'(0), m_valid, cur}, {187'(0), 1'b1, held});
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_bin", 256'(cur), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check(cur == e, "bin", 256'(cur), 256'(e));
                        if (e.last) exp_sready_next = 1;
                    end
                end
                if (o_timeout || cyc == exp_timeout_cyc) begin
                    check(o_timeout == (cyc == exp_timeout_cyc), "timeout_pulse",
                          256'(o_timeout), 256'(cyc == exp_timeout_cyc));
                end
                if (exp_timeout_cyc >= 0 && cyc == exp_timeout_cyc + 1) begin
                    check(s_ready == 1'b1, "sready_after_timeout", 256'(s_ready), 256'(1));
                end
                prev_stall   = m_valid && !m_ready;
                held         = cur;
                prev_m_valid = m_valid;
            end
        end
    end

    task automatic send_frame(input int gap);
        bit ok;
        int guard;
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_real  = tx_re[k];
            s_imag  = tx_im[k];
            guard = 0;
            do begin
                @(negedge i_clk);
                ok = s_ready;
                @(posedge i_clk);
                #1;
                guard++;
            end while (!ok && guard < 1000);
            if (!ok) check(1'b0, "sready_wait_expired", 256'(k), 256'(0));
            s_valid = 1'b0;
            repeat (gap) begin
                @(posedge i_clk);
                #1;
            end
        end
    endtask

    task automatic push_frame();
        for (int k = 0; k < 8; k++) exp_q.push_back(mk_bin(k));
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        do begin
            @(posedge i_clk);
            #2;
            guard++;
        end while (!(exp_q.size() == 0 && !m_valid && s_ready) && guard < 3000);
        if (guard >= 3000) check(1'b0, "frame_wait_expired", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({m_valid, m_last, o_fft_start, o_timeout, o_busy, s_ready} == 6'b0,
              {tag, "_ctrl_zero"},
              256'({m_valid, m_last, o_fft_start, o_timeout, o_busy, s_ready}), 256'(0));
        check({m_real, m_imag, m_idx} == 67'b0, {tag, "_data_zero"},
              256'({m_real, m_imag, m_idx}), 256'(0));
        check((o_fft_x_real | o_fft_x_imag) == 256'b0, {tag, "_fft_x_zero"},
              o_fft_x_real | o_fft_x_imag, 256'(0));
    endtask

    initial begin
        int s0;
        int t0;
        int guard;
        i_rst   = 1'b1;
        s_valid = 1'b0;
        s_real  = '0;
        s_imag  = '0;
        repeat (3) @(posedge i_clk);
        #2;
        check_zero_outputs("reset");
        i_rst = 1'b0;
        #1;
        check(s_ready == 1'b1, "sready_after_reset", 256'(s_ready), 256'(1));

        // 1: impulse, all bins 1.0 + 0j
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = (k == 0) ? 32'h3F80_0000 : 32'h0;
            tx_im[k] = 32'h0;
            exp_q.push_back({32'h3F80_0000, 32'h0, 3'(k), (k == 7)});
        end
        s0 = n_starts;
        send_frame(0);
        wait_done();
        check(n_starts - s0 == 1, "impulse_start_count", 256'(n_starts - s0), 256'(1));

        // 2: random backpressure
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 32'h4000_0000 | (32'(k) << 16) | 32'h0000_1234;
            tx_im[k] = 32'hBF80_0000 ^ 32'(k * 3);
        end
        push_frame();
        ready_mode = 2;
        send_frame(0);
        wait_done();
        ready_mode = 1;

        // 3: 3-cycle gaps between samples
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 32'h1111_1111 * 32'(k + 1);
            tx_im[k] = 32'hA5A5_0000 + 32'(k);
        end
        push_frame();
        send_frame(3);
        wait_done();

        // 4: core never finishes, then a normal frame
        model_mode = 1;
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 32'hDEAD_0000 + 32'(k);
            tx_im[k] = 32'hBEEF_0000 + 32'(k);
        end
        t0 = n_timeouts;
        send_frame(0);
        repeat (300) @(posedge i_clk);
        #2;
        check(n_timeouts - t0 == 1, "timeout_count", 256'(n_timeouts - t0), 256'(1));
        model_mode = 0;
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 32'h4120_0000 + 32'(k << 8);
            tx_im[k] = 32'hC120_0000 - 32'(k);
        end
        push_frame();
        send_frame(1);
        wait_done();

        // 5: done still high from the previous frame; only the later edge captures
        model_mode = 2;
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 32'h0F0F_0F0F ^ 32'(k << 4);
            tx_im[k] = 32'h7F7F_0000 | 32'(k);
        end
        push_frame();
        send_frame(0);
        wait_done();
        model_mode = 0;

        // 6: reset while bin 3 is on the output
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 32'h3300_0000 + 32'(k);
            tx_im[k] = 32'h4400_0000 + 32'(k);
        end
        push_frame();
        send_frame(0);
        guard = 0;
        do begin
            @(posedge i_clk);
            #2;
            guard++;
        end while (!(m_valid && m_idx == 3'd3) && guard < 200);
        check(m_valid && m_idx == 3'd3, "reach_bin3", 256'(m_idx), 256'(3));
        i_rst = 1'b1;
        @(posedge i_clk);
        #2;
        exp_q.delete();
        check_zero_outputs("midreset");
        i_rst = 1'b0;
        #1;
        check(s_ready == 1'b1, "sready_after_midreset", 256'(s_ready), 256'(1));
        for (int k = 0; k < 8; k++) begin
            tx_re[k] = 32'h5500_0000 + 32'(k * 7);
            tx_im[k] = 32'h6600_0000 + 32'(k * 5);
        end
        push_frame();
        send_frame(0);
        wait_done();

        repeat (5) @(posedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
